// File: rtl/bcd_seq_converter_if.sv
// Handshake/result bundle between the CPU result bus and the BCD converter.
// The master drives start/bin_in; the slave returns status and the packed BCD result.
interface bcd_seq_converter_if #(
  parameter int BINARY_WIDTH = 32,
  parameter int BCD_DIGITS   = 8
);
  logic                    start;
  logic [BINARY_WIDTH-1:0] bin_in;
  logic                    busy;
  logic                    done;
  logic [4*BCD_DIGITS-1:0] bcd_out;
  logic                    ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, with a
// saturating overflow flag and a result register held stable between conversions.
module bcd_seq_converter #(
  parameter int BINARY_WIDTH = 32,
  parameter int BCD_DIGITS   = 8,
  parameter int INT_DIGITS   = 10
) (
  input  logic               clk,
  input  logic               reset,
  bcd_seq_converter_if.slave bus
);
  localparam int ACC_W = 4 * INT_DIGITS;
  localparam int OUT_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BINARY_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [BINARY_WIDTH-1:0] shreg, shreg_nx;
  logic [ACC_W-1:0]        acc, acc_nx, acc_adj;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    busy, busy_nx;
  logic                    done, done_nx;
  logic [OUT_W-1:0]        bcd, bcd_nx;
  logic                    ovf, ovf_nx;

  // Every digit >= 5 gets +3 so the following left shift carries correctly into the next digit.
  function automatic logic [ACC_W-1:0] add3_all(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Next-state and datapath update logic.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    acc_nx   = acc;
    cnt_nx   = cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    bcd_nx   = bcd;
    ovf_nx   = ovf;
    acc_adj  = add3_all(acc);
    case (state)
      IDLE: begin
        if (bus.start) begin
          shreg_nx = bus.bin_in;
          acc_nx   = {ACC_W{1'b0}};
          cnt_nx   = {CNT_W{1'b0}};
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end else begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        acc_nx   = {acc_adj[ACC_W-2:0], shreg[BINARY_WIDTH-1]};
        shreg_nx = {shreg[BINARY_WIDTH-2:0], 1'b0};
        cnt_nx   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BINARY_WIDTH - 1)) begin
          state_nx = FINISH;
        end else begin
          state_nx = SHIFT;
        end
      end
      FINISH: begin
        // Any nonzero digit beyond the displayed ones saturates the display to all-9.
        if (acc[ACC_W-1:OUT_W] != {(ACC_W-OUT_W){1'b0}}) begin
          ovf_nx = 1'b1;
          bcd_nx = {BCD_DIGITS{4'h9}};
        end else begin
          ovf_nx = 1'b0;
          bcd_nx = acc[OUT_W-1:0];
        end
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= {BINARY_WIDTH{1'b0}};
      acc   <= {ACC_W{1'b0}};
      cnt   <= {CNT_W{1'b0}};
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= {OUT_W{1'b0}};
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      bcd   <= bcd_nx;
      ovf   <= ovf_nx;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.bcd_out = bcd;
  assign bus.ovf     = ovf;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: directed corner cases plus random
// values compared against a decimal-arithmetic reference model.
module tb_bcd_seq_converter;
  logic clk;
  logic reset;
  int   total_cnt;
  int   pass_cnt;

  bcd_seq_converter_if #(.BINARY_WIDTH(32), .BCD_DIGITS(8)) bus ();

  bcd_seq_converter #(.BINARY_WIDTH(32), .BCD_DIGITS(8), .INT_DIGITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_model(input logic [31:0] v, output logic [31:0] b, output logic o);
    longint unsigned x;
    x = 64'(v);
    b = 32'h0;
    if (x > 64'd99999999) begin
      b = 32'h99999999;
      o = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        b[4*i +: 4] = 4'(x % 64'd10);
        x = x / 64'd10;
      end
      o = 1'b0;
    end
  endfunction

  // Called at a negedge with the DUT idle or in its done cycle; returns at the negedge after done.
  task automatic convert(input logic [31:0] v, output int lat, output int busy_n,
                         output logic [31:0] b, output logic o, output logic held);
    logic [31:0] prev_b;
    logic        prev_o;
    prev_b = bus.bcd_out;
    prev_o = bus.ovf;
    held   = 1'b1;
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(negedge clk);
    bus.start = 1'b0;
    busy_n = (bus.busy === 1'b1) ? 1 : 0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.bcd_out !== prev_b || bus.ovf !== prev_o) held = 1'b0;
      bus.bin_in = $urandom;
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) busy_n++;
    end
    b = bus.bcd_out;
    o = bus.ovf;
  endtask

  task automatic test_reset();
    bus.start  = 1'b1;
    bus.bin_in = 32'd77;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 32'h0 || bus.ovf !== 1'b0)
      $display("FAIL reset_state: busy=%b done=%b bcd=%h ovf=%b, want 0 0 00000000 0",
               bus.busy, bus.done, bus.bcd_out, bus.ovf);
    else pass_cnt++;
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [31:0] vals [6];
    logic [31:0] b, eb;
    logic        o, eo, held;
    int          lat, bn;
    vals = '{32'd0, 32'd12345678, 32'd99999999, 32'd100000000, 32'hFFFFFFFF, 32'd7};
    foreach (vals[i]) begin
      convert(vals[i], lat, bn, b, o, held);
      ref_model(vals[i], eb, eo);
      total_cnt++;
      if (lat !== 33) $display("FAIL latency_%0d: got %0d cycles, want 33", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (bn !== 33) $display("FAIL busy_len_%0d: got %0d cycles, want 33", i, bn);
      else pass_cnt++;
      total_cnt++;
      if (b !== eb || o !== eo)
        $display("FAIL result_%0d (bin %0d): got %h ovf=%b, want %h ovf=%b", i, vals[i], b, o, eb, eo);
      else pass_cnt++;
      total_cnt++;
      if (held !== 1'b1) $display("FAIL hold_%0d: output changed before done", i);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.done !== 1'b0 || bus.bcd_out !== eb)
        $display("FAIL done_pulse_%0d: done=%b bcd=%h, want 0 %h", i, bus.done, bus.bcd_out, eb);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] v, b, eb;
    logic        o, eo, held;
    int          lat, bn;
    for (int k = 0; k < 16; k++) begin
      v = (k % 2 == 0) ? 32'($urandom_range(0, 99999999)) : 32'($urandom);
      convert(v, lat, bn, b, o, held);
      ref_model(v, eb, eo);
      total_cnt++;
      if (b !== eb || o !== eo || lat !== 33)
        $display("FAIL random_%0d (bin %0d): got %h ovf=%b lat=%0d, want %h ovf=%b lat=33",
                 k, v, b, o, lat, eb, eo);
      else pass_cnt++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    bus.start  = 1'b1;
    bus.bin_in = 32'd42;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (lat == 9) begin
        bus.start  = 1'b1;
        bus.bin_in = 32'd55;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    total_cnt++;
    if (lat !== 33 || bus.bcd_out !== 32'h00000042 || bus.ovf !== 1'b0)
      $display("FAIL ignore_start: got %h ovf=%b lat=%0d, want 00000042 ovf=0 lat=33",
               bus.bcd_out, bus.ovf, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    logic        o, held;
    int          lat, bn;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL b2b_in_done: done=%b busy=%b, want 1 0", bus.done, bus.busy);
    else pass_cnt++;
    convert(32'd9, lat, bn, b, o, held);
    total_cnt++;
    if (lat !== 33 || b !== 32'h00000009 || o !== 1'b0)
      $display("FAIL back_to_back: got %h ovf=%b lat=%0d, want 00000009 ovf=0 lat=33", b, o, lat);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [31:0] b;
    logic        o, held;
    int          lat, bn, seen;
    bus.start  = 1'b1;
    bus.bin_in = 32'd1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 32'h0 || bus.ovf !== 1'b0)
      $display("FAIL reset_abort: busy=%b done=%b bcd=%h ovf=%b, want 0 0 00000000 0",
               bus.busy, bus.done, bus.bcd_out, bus.ovf);
    else pass_cnt++;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL abort_quiet: %0d cycles with busy/done, want 0", seen);
    else pass_cnt++;
    convert(32'd5, lat, bn, b, o, held);
    total_cnt++;
    if (lat !== 33 || b !== 32'h00000005 || o !== 1'b0)
      $display("FAIL after_abort: got %h ovf=%b lat=%0d, want 00000005 ovf=0 lat=33", b, o, lat);
    else pass_cnt++;
  endtask

  initial begin
    total_cnt  = 0;
    pass_cnt   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = 32'h0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
